// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: one bit per cycle on operand magnitudes,
// followed by a sign-fix cycle that commits the result to HI/LO.
module mips_cpu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_signed;
    logic               is_div;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   opnd;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Datapath helpers: magnitudes, one iteration step, final sign correction.
    always_comb begin
        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];
        a_mag     = a_neg ? WIDTH'(-a_q) : a_q;
        b_mag     = b_neg ? WIDTH'(-b_q) : b_q;
        mul_sum   = acc + {1'b0, (shreg[0] ? opnd : {WIDTH{1'b0}})};
        div_shift = {acc[WIDTH-1:0], shreg[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        prod      = {acc[WIDTH-1:0], shreg};
        prod_fix  = (a_neg ^ b_neg) ? (2*WIDTH)'(-prod) : prod;
        fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo    = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_q == '0) begin
                // Divide by zero: quotient all ones, remainder is the dividend as given.
                fix_hi = a_q;
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_hi = a_neg ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                fix_lo = (a_neg ^ b_neg) ? WIDTH'(-shreg) : shreg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            is_signed <= 1'b0;
            is_div    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            shreg     <= '0;
            opnd      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                a_q       <= a;
                                b_q       <= b;
                                is_signed <= ~op[0];
                                is_div    <= op[1];
                                cnt       <= '0;
                                busy      <= 1'b1;
                                state     <= op[1] ? DIV : MUL;
                            end
                            3'b100:  hi <= a;
                            3'b101:  lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    // First cycle loads magnitudes; the next WIDTH cycles each retire one bit.
                    if (cnt == '0) begin
                        acc   <= '0;
                        shreg <= is_div ? a_mag : b_mag;
                        opnd  <= is_div ? b_mag : a_mag;
                    end else if (state == MUL) begin
                        acc   <= {1'b0, mul_sum[WIDTH:1]};
                        shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
                    end else if (div_diff[WIDTH+1]) begin
                        acc   <= div_shift;
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        acc   <= div_diff[WIDTH:0];
                        shreg <= {shreg[WIDTH-2:0], 1'b1};
                    end
                    if (cnt == CW'(WIDTH)) begin
                        state <= FIX;
                    end
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Randomized self-checking bench for mips_cpu_muldiv against an arithmetic HI/LO model.
module tb_mips_cpu_muldiv;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;

    mips_cpu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        int     ix;
        int     iy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ix = $signed(x);
        iy = $signed(y);
        r  = 64'd0;
        case (o)
            3'b000: r = 64'(sx * sy);
            3'b001: r = {32'd0, x} * {32'd0, y};
            3'b010: begin
                if (y == 32'd0)                                r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else                                           r = {32'(ix % iy), 32'(ix / iy)};
            end
            3'b011: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else            r = {x % y, x / y};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'd1;
            4:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Launch a MULT/DIV, optionally poke ignored starts while busy, check timing and result.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit inject);
        logic [63:0] res;
        int          poke;
        res   = model(o, x, y);
        poke  = int'($urandom_range(1, W));
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        for (int i = 0; i <= int'(W) + 1; i++) begin
            check("busy_high", 64'(busy), 64'd1);
            if (i == 0) check("done_single", 64'(done), 64'd0);
            if (i == poke || i == int'(W)) check("hilo_stable", {hi, lo}, {exp_hi, exp_lo});
            start = (inject && i == poke) ? 1'b1 : 1'b0;
            op    = 3'($urandom_range(0, 7));
            a     = $urandom;
            b     = $urandom;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        check("done_pulse", 64'(done), 64'd1);
        check("busy_low", 64'(busy), 64'd0);
        check("hi", 64'(hi), 64'(exp_hi));
        check("lo", 64'(lo), 64'(exp_lo));
    endtask

    // Single-cycle ops (MTHI/MTLO/no-op) issued from idle.
    task automatic do_mt(input logic [2:0] o, input logic [31:0] x);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (o == 3'b100) exp_hi = x;
        if (o == 3'b101) exp_lo = x;
        check("mt_hi", 64'(hi), 64'(exp_hi));
        check("mt_lo", 64'(lo), 64'(exp_lo));
        check("mt_busy", 64'(busy), 64'd0);
        check("mt_done", 64'(done), 64'd0);
    endtask

    initial begin
        logic [2:0] ro;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        exp_hi = '0;
        exp_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        do_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        check("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg_lo", 64'(lo), 64'hFFFF_FFFA);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        check("divu", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
        do_op(3'b011, 32'h0000_1234, 32'h0000_0000, 1'b0);
        check("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        do_mt(3'b100, 32'hDEAD_BEEF);
        check("mthi_val", 64'(hi), 64'h0000_0000_DEAD_BEEF);
        check("mthi_lo_kept", 64'(lo), 64'h0000_0000_8000_0000);
        do_mt(3'b110, 32'h1111_1111);
        do_op(3'b000, 32'd7, 32'd6, 1'b1);
        check("inject_ignored", {hi, lo}, 64'd42);

        // Reset mid-multiply aborts with no result and no done.
        start = 1'b1;
        op    = 3'b000;
        a     = 32'h0001_0001;
        b     = 32'h0000_0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < int'(W) + 4; i++) begin
            check("abort_nodone", 64'(done), 64'd0);
            @(posedge clk);
            #1;
        end
        check("abort_hilo_after", {hi, lo}, 64'd0);
        do_op(3'b000, 32'd3, 32'd5, 1'b0);
        check("mult_3x5", {hi, lo}, 64'h0000_0000_0000_000F);

        // Reset wins over a simultaneous MTHI start.
        reset = 1'b1;
        start = 1'b1;
        op    = 3'b100;
        a     = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        start  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("rst_prio", {hi, lo}, 64'd0);

        // Random mix; back-to-back launches land on the done cycle.
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            if (ro <= 3'b011) do_op(ro, pick_val(), pick_val(), 1'($urandom_range(0, 1)));
            else              do_mt(ro, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
